// File: rtl/wb_traffic_pkg.sv
// Shared types and constants for the Wishbone traffic master.
// Includes the LFSR step and saturating counter helpers.
package wb_traffic_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StWr,
        StRd,
        StNext
    } state_e;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam logic [2:0]  CTI_CLASSIC = 3'b000;
    localparam logic [1:0]  BTE_LINEAR  = 2'b00;

    // Right-shifting Galois form; a non-zero state never maps to zero.
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/wb_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load; load has priority over step.
module wb_lfsr32
    import wb_traffic_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = 32'h1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] seed,
    input  logic        load,
    input  logic        step,
    output logic [31:0] value
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            value <= RESET_VALUE;
        end else if (load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/wb_traffic_master.sv
// Self-checking Wishbone classic master: writes LFSR bursts to each region window,
// reads them back, and keeps pass/error counters plus a sticky fail flag.
module wb_traffic_master
    import wb_traffic_pkg::*;
#(
    parameter int unsigned WB_ADDR_WIDTH = 32,
    parameter int unsigned WB_DATA_WIDTH = 32,
    parameter int unsigned NUM_REGIONS   = 4,
    parameter int unsigned BURST_LEN     = 8,
    parameter int unsigned ACK_TIMEOUT   = 255,
    parameter logic [31:0] LFSR_SEED     = 32'h1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       en,
    input  logic [WB_ADDR_WIDTH-1:0]   addr_base_0,
    input  logic [WB_ADDR_WIDTH-1:0]   addr_base_1,
    input  logic [WB_ADDR_WIDTH-1:0]   addr_base_2,
    input  logic [WB_ADDR_WIDTH-1:0]   addr_base_3,
    output logic [WB_ADDR_WIDTH-1:0]   ADR,
    output logic [WB_DATA_WIDTH-1:0]   DAT_W,
    input  logic [WB_DATA_WIDTH-1:0]   DAT_R,
    output logic [WB_DATA_WIDTH/8-1:0] SEL,
    output logic                       CYC,
    output logic                       STB,
    output logic                       WE,
    input  logic                       ACK,
    input  logic                       ERR,
    output logic [2:0]                 CTI,
    output logic [1:0]                 BTE,
    output logic [31:0]                pass_cnt,
    output logic [31:0]                err_cnt,
    output logic                       fail
);

    localparam int unsigned BYTE_SHIFT = $clog2(WB_DATA_WIDTH / 8);
    localparam int unsigned WW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned TW = ($clog2(ACK_TIMEOUT + 1) > 8) ? $clog2(ACK_TIMEOUT + 1) : 8;
    localparam logic [WW-1:0] LAST_WORD   = WW'(BURST_LEN - 1);
    localparam logic [1:0]    LAST_REGION = 2'(NUM_REGIONS - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(ACK_TIMEOUT - 1);

    state_e                   state;
    logic [1:0]               region;
    logic [WW-1:0]            word;
    logic [31:0]              visit_seed;
    logic                     visit_err;
    logic [TW-1:0]            tmo;

    logic [31:0]              lfsr_value;
    logic                     lfsr_load;
    logic                     lfsr_step;
    logic [WB_ADDR_WIDTH-1:0] base_sel;
    logic [WB_ADDR_WIDTH-1:0] word_adr;
    logic                     timed_out;
    logic                     term;
    logic                     rd_bad;
    logic                     xfer_err;
    logic                     last_word;
    logic                     in_xfer_state;

    assign SEL = '1;
    assign CTI = CTI_CLASSIC;
    assign BTE = BTE_LINEAR;

    always_comb begin
        base_sel = addr_base_0;
        case (region)
            2'd0:    base_sel = addr_base_0;
            2'd1:    base_sel = addr_base_1;
            2'd2:    base_sel = addr_base_2;
            default: base_sel = addr_base_3;
        endcase
    end

    assign word_adr      = base_sel + (WB_ADDR_WIDTH'(word) << BYTE_SHIFT);
    assign last_word     = (word == LAST_WORD);
    assign in_xfer_state = (state == StWr) || (state == StRd);

    // ACK together with ERR counts as ERR; a read compare only happens on a clean ACK.
    assign timed_out = STB && !ACK && !ERR && (tmo == TMO_LAST);
    assign term      = STB && (ACK || ERR || timed_out);
    assign rd_bad    = (state == StRd) && ACK && !ERR && (DAT_R != WB_DATA_WIDTH'(lfsr_value));
    assign xfer_err  = term && (ERR || timed_out || rd_bad);

    always_comb begin
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        if (term) begin
            if ((state == StWr) && last_word) begin
                lfsr_load = 1'b1;
            end else begin
                lfsr_step = 1'b1;
            end
        end
        // Parking mid-visit rewinds to the visit seed so a resume replays the same data.
        if (in_xfer_state && !STB && !en) begin
            lfsr_load = 1'b1;
        end
    end

    wb_lfsr32 #(
        .RESET_VALUE (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rstn  (rstn),
        .seed  (visit_seed),
        .load  (lfsr_load),
        .step  (lfsr_step),
        .value (lfsr_value)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StIdle;
            region     <= 2'd0;
            word       <= '0;
            visit_seed <= LFSR_SEED;
            visit_err  <= 1'b0;
            tmo        <= '0;
            CYC        <= 1'b0;
            STB        <= 1'b0;
            WE         <= 1'b0;
            ADR        <= '0;
            DAT_W      <= '0;
            pass_cnt   <= '0;
            err_cnt    <= '0;
            fail       <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (en) begin
                        state      <= StWr;
                        word       <= '0;
                        visit_seed <= lfsr_value;
                        visit_err  <= 1'b0;
                    end
                end
                StWr, StRd: begin
                    if (STB) begin
                        if (term) begin
                            CYC <= 1'b0;
                            STB <= 1'b0;
                            WE  <= 1'b0;
                            if (last_word) begin
                                word  <= '0;
                                state <= (state == StWr) ? StRd : StNext;
                            end else begin
                                word <= word + WW'(1);
                            end
                        end else begin
                            tmo <= tmo + TW'(1);
                        end
                    end else if (!en) begin
                        state <= StIdle;
                    end else begin
                        CYC <= 1'b1;
                        STB <= 1'b1;
                        WE  <= (state == StWr);
                        ADR <= word_adr;
                        tmo <= '0;
                        if (state == StWr) begin
                            DAT_W <= WB_DATA_WIDTH'(lfsr_value);
                        end
                    end
                end
                StNext: begin
                    if (!visit_err) begin
                        pass_cnt <= sat_inc(pass_cnt);
                    end
                    region     <= (region == LAST_REGION) ? 2'd0 : region + 2'd1;
                    visit_err  <= 1'b0;
                    visit_seed <= lfsr_value;
                    state      <= en ? StWr : StIdle;
                end
                default: state <= StIdle;
            endcase

            if (xfer_err) begin
                err_cnt   <= sat_inc(err_cnt);
                fail      <= 1'b1;
                visit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wb_traffic_master.sv
// Directed bench for wb_traffic_master with a zero-wait memory slave and fault knobs.
module tb_wb_traffic_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en;
    logic [31:0] ADR;
    logic [31:0] DAT_W;
    logic [31:0] DAT_R;
    logic [3:0]  SEL;
    logic        CYC, STB, WE, ACK, ERR;
    logic [2:0]  CTI;
    logic [1:0]  BTE;
    logic [31:0] pass_cnt, err_cnt;
    logic        fail;

    always #5 clk = ~clk;

    wb_traffic_master #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .NUM_REGIONS   (4),
        .BURST_LEN     (8),
        .ACK_TIMEOUT   (16),
        .LFSR_SEED     (32'h1)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .addr_base_0 (32'h000),
        .addr_base_1 (32'h100),
        .addr_base_2 (32'h200),
        .addr_base_3 (32'h300),
        .ADR         (ADR),
        .DAT_W       (DAT_W),
        .DAT_R       (DAT_R),
        .SEL         (SEL),
        .CYC         (CYC),
        .STB         (STB),
        .WE          (WE),
        .ACK         (ACK),
        .ERR         (ERR),
        .CTI         (CTI),
        .BTE         (BTE),
        .pass_cnt    (pass_cnt),
        .err_cnt     (err_cnt),
        .fail        (fail)
    );

    // Zero-wait slave: terminates in the same cycle STB is seen.
    logic [31:0] mem [0:255];
    logic corrupt_on = 1'b0, err_on = 1'b0, both_on = 1'b0, noack_on = 1'b0, noack_all = 1'b0;
    logic hit_corrupt, hit_err, hit_both, hit_noack;

    always_comb begin
        hit_corrupt = corrupt_on && !WE && (ADR == 32'h10C);
        hit_err     = err_on && WE && (ADR == 32'h200);
        hit_both    = both_on && WE && (ADR == 32'h300);
        hit_noack   = noack_all || (noack_on && WE && (ADR == 32'h000));
        ACK         = CYC && STB && !hit_noack && !hit_err;
        ERR         = CYC && STB && (hit_err || hit_both);
        DAT_R       = mem[ADR[9:2]] ^ {31'b0, hit_corrupt};
    end

    always @(posedge clk) begin
        if (CYC && STB && WE && (ACK || ERR)) mem[ADR[9:2]] <= DAT_W;
    end

    // Transfer log, one entry per STB rise; lengths pushed on STB fall.
    logic [31:0] adr_q[$];
    logic [31:0] dat_q[$];
    logic        we_q[$];
    int          cyc_q[$];
    int          len_q[$];
    int          cycle_n = 0;
    int          cur_len = 0;
    logic        stb_prev = 1'b0;

    always @(posedge clk) cycle_n <= cycle_n + 1;

    always @(negedge clk) begin
        if (STB && !stb_prev) begin
            adr_q.push_back(ADR);
            dat_q.push_back(DAT_W);
            we_q.push_back(WE);
            cyc_q.push_back(cycle_n);
        end
        if (!STB && stb_prev) len_q.push_back(cur_len);
        cur_len  <= (STB && !stb_prev) ? 1 : (STB ? cur_len + 1 : cur_len);
        stb_prev <= STB;
    end

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_xfers(input int n, input int budget);
        int i;
        i = 0;
        while (adr_q.size() < n && i < budget) begin
            cycles(1);
            i++;
        end
        if (adr_q.size() < n) check_eq("xfer_wait", 64'(adr_q.size()), 64'(n));
    endtask

    task automatic wait_pass(input logic [31:0] n, input int budget);
        int i;
        i = 0;
        while (pass_cnt < n && i < budget) begin
            cycles(1);
            i++;
        end
        if (pass_cnt < n) check_eq("pass_wait", 64'(pass_cnt), 64'(n));
    endtask

    task automatic do_reset();
        en   = 1'b0;
        rstn = 1'b0;
        cycles(2);
        rstn = 1'b1;
        cycles(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int b;
    int lb;

    initial begin
        rstn = 1'b0;
        en   = 1'b0;
        cycles(2);
        check_eq("rst_cyc", 64'(CYC), 64'd0);
        check_eq("rst_stb", 64'(STB), 64'd0);
        check_eq("rst_we", 64'(WE), 64'd0);
        check_eq("rst_adr", 64'(ADR), 64'd0);
        check_eq("rst_datw", 64'(DAT_W), 64'd0);
        check_eq("rst_pass", 64'(pass_cnt), 64'd0);
        check_eq("rst_err", 64'(err_cnt), 64'd0);
        check_eq("rst_fail", 64'(fail), 64'd0);
        check_eq("rst_sel", 64'(SEL), 64'hF);
        check_eq("rst_cti_bte", 64'({CTI, BTE}), 64'd0);

        // Clean traffic over four regions, then the wrap back to region 0.
        do_reset();
        b  = adr_q.size();
        en = 1'b1;
        wait_pass(32'd4, 200);
        wait_xfers(b + 65, 20);
        en = 1'b0;
        check_eq("a_pass", 64'(pass_cnt), 64'd4);
        check_eq("a_err", 64'(err_cnt), 64'd0);
        check_eq("a_fail", 64'(fail), 64'd0);
        check_eq("a_adr0", 64'(adr_q[b]), 64'h000);
        check_eq("a_adr7", 64'(adr_q[b + 7]), 64'h01C);
        check_eq("a_rd0_adr", 64'(adr_q[b + 8]), 64'h000);
        check_eq("a_rd0_we", 64'(we_q[b + 8]), 64'd0);
        check_eq("a_wr0_we", 64'(we_q[b]), 64'd1);
        check_eq("a_adr_r1", 64'(adr_q[b + 16]), 64'h100);
        check_eq("a_adr_r2", 64'(adr_q[b + 32]), 64'h200);
        check_eq("a_adr_r3", 64'(adr_q[b + 48]), 64'h300);
        check_eq("a_adr_wrap", 64'(adr_q[b + 64]), 64'h000);
        check_eq("a_dat0", 64'(dat_q[b]), 64'h0000_0001);
        check_eq("a_dat1", 64'(dat_q[b + 1]), 64'h8020_0003);
        check_eq("a_dat2", 64'(dat_q[b + 2]), 64'hC030_0002);
        check_eq("a_dat7", 64'(dat_q[b + 7]), 64'hB62D_8003);
        check_eq("a_dat_v1", 64'(dat_q[b + 16]), 64'hDB36_C002);
        check_eq("a_gap", 64'(cyc_q[b + 1] - cyc_q[b]), 64'd2);
        check_eq("a_visit_len", 64'(cyc_q[b + 16] - cyc_q[b]), 64'd33);

        // Read word 3 of region 1 corrupted.
        do_reset();
        corrupt_on = 1'b1;
        en = 1'b1;
        wait_pass(32'd1, 60);
        cycles(40);
        check_eq("b_pass_after_v1", 64'(pass_cnt), 64'd1);
        check_eq("b_err_after_v1", 64'(err_cnt), 64'd1);
        check_eq("b_fail", 64'(fail), 64'd1);
        wait_pass(32'd3, 120);
        en = 1'b0;
        check_eq("b_pass_end", 64'(pass_cnt), 64'd3);
        check_eq("b_err_end", 64'(err_cnt), 64'd1);
        corrupt_on = 1'b0;

        // ERR on first write of region 2, ACK+ERR on first write of region 3.
        do_reset();
        err_on  = 1'b1;
        both_on = 1'b1;
        b  = adr_q.size();
        en = 1'b1;
        wait_xfers(b + 49, 200);
        check_eq("c_err_once", 64'(err_cnt), 64'd1);
        check_eq("c_adr_err", 64'(adr_q[b + 32]), 64'h200);
        check_eq("c_adr_after", 64'(adr_q[b + 33]), 64'h204);
        wait_xfers(b + 65, 60);
        en = 1'b0;
        check_eq("c_err_both", 64'(err_cnt), 64'd2);
        check_eq("c_pass", 64'(pass_cnt), 64'd2);
        check_eq("c_fail", 64'(fail), 64'd1);
        err_on  = 1'b0;
        both_on = 1'b0;

        // First write never acknowledged.
        do_reset();
        noack_on = 1'b1;
        b  = adr_q.size();
        lb = len_q.size();
        en = 1'b1;
        wait_xfers(b + 2, 60);
        check_eq("d_stb_len", 64'(len_q[lb]), 64'd16);
        check_eq("d_next_adr", 64'(adr_q[b + 1]), 64'h004);
        check_eq("d_err", 64'(err_cnt), 64'd1);
        check_eq("d_fail", 64'(fail), 64'd1);

        // Asynchronous reset while STB is held high.
        noack_all = 1'b1;
        wait_xfers(b + 3, 40);
        check_eq("f_pre_stb", 64'(STB), 64'd1);
        #2 rstn = 1'b0;
        #1;
        check_eq("f_cyc", 64'(CYC), 64'd0);
        check_eq("f_stb", 64'(STB), 64'd0);
        check_eq("f_err", 64'(err_cnt), 64'd0);
        check_eq("f_fail", 64'(fail), 64'd0);
        noack_all = 1'b0;
        noack_on  = 1'b0;

        // en dropped during read word 5, then resumed.
        do_reset();
        b  = adr_q.size();
        en = 1'b1;
        wait_xfers(b + 14, 60);
        en = 1'b0;
        check_eq("e_rd5_adr", 64'(adr_q[b + 13]), 64'h014);
        check_eq("e_rd5_we", 64'(we_q[b + 13]), 64'd0);
        cycles(10);
        check_eq("e_idle_cyc", 64'(CYC), 64'd0);
        check_eq("e_no_more", 64'(adr_q.size()), 64'(b + 14));
        en = 1'b1;
        wait_xfers(b + 16, 20);
        check_eq("e_resume_adr", 64'(adr_q[b + 14]), 64'h000);
        check_eq("e_resume_we", 64'(we_q[b + 14]), 64'd1);
        check_eq("e_resume_dat0", 64'(dat_q[b + 14]), 64'h0000_0001);
        check_eq("e_resume_dat1", 64'(dat_q[b + 15]), 64'h8020_0003);
        wait_pass(32'd1, 60);
        en = 1'b0;
        check_eq("e_pass", 64'(pass_cnt), 64'd1);
        check_eq("e_err", 64'(err_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
